// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forwarding-select constants and the scoreboard entry layout.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_LDUSE  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_MWAIT  = 3'd3,
    ST_HALTED = 3'd4
  } hz_state_e;

  localparam int              FWD_W     = 3;
  localparam logic [FWD_W-1:0] FWD_RF   = '0;
  localparam logic [15:0]     NOP_INSTR = 16'h0800;
  localparam int              CNT_W     = 16;

  // Per-slot flags; the destination select is stored beside it because its
  // width follows the REG_W parameter of the instantiating module.
  typedef struct packed {
    logic valid;
    logic is_load;
  } sb_flags_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Destination scoreboard for in-flight instructions (slot 0 = EX) with the
// youngest-producer forwarding encoder and load-use detection.
module pipe_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = 3,
  parameter int SB_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_sel,
  input  logic             in_load,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  output logic [FWD_W-1:0] fwd_a_nxt,
  output logic [FWD_W-1:0] fwd_b_nxt,
  output logic             load_use
);

  sb_flags_t        flags_q [SB_DEPTH];
  logic [REG_W-1:0] sel_q   [SB_DEPTH];

  // NOTE: every slot is cleared on reset, not just the valid bits; this is a
  // handful of flops rather than a RAM, so there is no cost to doing so and
  // the select fields never carry X into the comparators.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        flags_q[i] <= '0;
        sel_q[i]   <= '0;
      end
    end else if (shift_en) begin
      flags_q[0] <= '{valid: in_valid, is_load: in_load};
      sel_q[0]   <= in_sel;
      for (int i = 1; i < SB_DEPTH; i++) begin
        flags_q[i] <= flags_q[i-1];
        sel_q[i]   <= sel_q[i-1];
      end
    end
  end

  // Walk from the oldest slot to the youngest so the youngest match is the
  // last write; a load still in EX can never be a forwarding source.
  always_comb begin
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    for (int k = SB_DEPTH; k >= 1; k--) begin
      if (flags_q[k-1].valid && !(k == 1 && flags_q[0].is_load)) begin
        if (id_rs_use && (sel_q[k-1] == id_rs)) fwd_a_nxt = FWD_W'(k);
        if (id_rt_use && (sel_q[k-1] == id_rt)) fwd_b_nxt = FWD_W'(k);
      end
    end
  end

  assign load_use = id_valid && flags_q[0].valid && flags_q[0].is_load &&
                    ((id_rs_use && (sel_q[0] == id_rs)) ||
                     (id_rt_use && (sel_q[0] == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: priority FSM for memory wait, redirect flush,
// load-use interlock, fetch stall and halt, plus registered forwarding selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = 3,
  parameter int SB_DEPTH    = 3,
  parameter int FLUSH_SLOTS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_sel,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             stall_f,
  input  logic             stall_m,
  input  logic             halt_m,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_bubble,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [2:0]       fwd_a_sel,
  output logic [2:0]       fwd_b_sel,
  output logic [15:0]      stall_cnt,
  output logic             err
);

  hz_state_e        state_q, state_d;
  logic [7:0]       flush_q, flush_d;
  logic [CNT_W-1:0] wd_q, stall_cnt_q;
  logic             err_q, err_set;
  logic [FWD_W-1:0] fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;
  logic             load_use, freeze, wd_active, wd_trip;

  assign freeze    = stall_m || (state_q == ST_HALTED);
  assign wd_active = stall_m && (state_q != ST_HALTED);
  assign wd_trip   = (TIMEOUT != 0) && wd_active &&
                     (({1'b0, wd_q} + 17'd1) >= 17'(TIMEOUT));

  pipe_scoreboard #(
    .REG_W    (REG_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (!freeze),
    .in_valid  (id_valid && id_wr_en && !idex_bubble),
    .in_sel    (id_wr_sel),
    .in_load   (id_is_load),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rs_use (id_rs_use),
    .id_rt_use (id_rt_use),
    .fwd_a_nxt (fwd_a_nxt),
    .fwd_b_nxt (fwd_b_nxt),
    .load_use  (load_use)
  );

  // NOTE: every output and next-state variable gets a default before any
  // branch so no path through this block can leave one unassigned (latch).
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_bubble  = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    flush_d      = flush_q;
    err_set      = 1'b0;
    if (rst) begin
      ifid_bubble = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
    end else begin
      case (state_q)
        ST_HALTED: begin
          pc_hold      = 1'b1;
          ifid_hold    = 1'b1;
          idex_hold    = 1'b1;
          exmem_hold   = 1'b1;
          ifid_bubble  = 1'b1;
          memwb_bubble = 1'b1;
        end
        ST_RUN, ST_LDUSE, ST_FLUSH, ST_MWAIT: begin
          if (stall_m) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = ST_MWAIT;
          end else if (ex_redirect) begin
            ifid_bubble = 1'b1;
            idex_bubble = 1'b1;
            flush_d     = 8'(FLUSH_SLOTS - 1);
            state_d     = (FLUSH_SLOTS > 1) ? ST_FLUSH : ST_RUN;
          end else begin
            // The ID slot holds a squashed instruction while flushing, so
            // the load-use interlock does not apply there.
            if (state_q == ST_FLUSH) begin
              ifid_bubble = 1'b1;
              pc_hold     = stall_f;
              flush_d     = flush_q - 8'd1;
              state_d     = (flush_q > 8'd1) ? ST_FLUSH : ST_RUN;
            end else if (load_use) begin
              pc_hold     = 1'b1;
              ifid_hold   = 1'b1;
              idex_bubble = 1'b1;
              state_d     = ST_LDUSE;
            end else if (stall_f) begin
              pc_hold     = 1'b1;
              ifid_bubble = 1'b1;
              state_d     = ST_RUN;
            end else begin
              state_d = ST_RUN;
            end
            if (halt_m && !pc_hold) state_d = ST_HALTED;
          end
        end
        default: begin
          err_set = 1'b1;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q        <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
    end else begin
      wd_q        <= wd_active ? sat_inc(wd_q, 1'b1) : '0;
      stall_cnt_q <= sat_inc(stall_cnt_q, pc_hold);
      err_q       <= err_q || err_set || wd_trip;
      // Forward selects travel with ID/EX: held when it holds, cleared with
      // a bubble.
      if (!freeze) begin
        fwd_a_q <= idex_bubble ? FWD_RF : fwd_a_nxt;
        fwd_b_q <= idex_bubble ? FWD_RF : fwd_b_nxt;
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by random traffic, all compared every cycle against a queue-based model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W       = 3;
  localparam int SB_DEPTH    = 3;
  localparam int FLUSH_SLOTS = 2;
  localparam int TIMEOUT     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_rs_use, id_rt_use, id_wr_en, id_is_load;
  logic [REG_W-1:0] id_rs, id_rt, id_wr_sel;
  logic             ex_redirect, stall_f, stall_m, halt_m;
  logic             pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble;
  logic             exmem_hold, memwb_bubble, err;
  logic [2:0]       fwd_a_sel, fwd_b_sel;
  logic [15:0]      stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W       (REG_W),
    .SB_DEPTH    (SB_DEPTH),
    .FLUSH_SLOTS (FLUSH_SLOTS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_use    (id_rs_use),
    .id_rt_use    (id_rt_use),
    .id_wr_en     (id_wr_en),
    .id_wr_sel    (id_wr_sel),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .stall_f      (stall_f),
    .stall_m      (stall_m),
    .halt_m       (halt_m),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_bubble  (ifid_bubble),
    .idex_hold    (idex_hold),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .memwb_bubble (memwb_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cnt    (stall_cnt),
    .err          (err)
  );

  // Reference model: in-flight producers as a queue (index 0 = in EX).
  typedef struct {
    bit valid;
    int sel;
    bit load;
  } prod_t;

  prod_t prods[$];
  bit    m_known, m_halted, m_err;
  int    m_flush_left, m_wd, m_stall_cnt, m_fwd_a, m_fwd_b;
  bit    e_pc_hold, e_ifid_hold, e_ifid_bubble, e_idex_hold, e_idex_bubble;
  bit    e_exmem_hold, e_memwb_bubble;

  logic        s_pc_hold, s_ifid_hold, s_ifid_bubble, s_idex_bubble, s_idex_hold;
  logic        s_memwb_bubble, s_err;
  logic [2:0]  s_fwd_a;
  logic [15:0] s_stall_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int youngest(input int r, input bit used);
    if (!used) return 0;
    for (int k = 1; k <= SB_DEPTH; k++) begin
      if (prods[k-1].valid && prods[k-1].sel == r && !(k == 1 && prods[0].load)) return k;
    end
    return 0;
  endfunction

  function automatic bit model_load_use();
    return id_valid && prods[0].valid && prods[0].load &&
           ((id_rs_use && int'(id_rs) == prods[0].sel) ||
            (id_rt_use && int'(id_rt) == prods[0].sel));
  endfunction

  task automatic model_outputs();
    {e_pc_hold, e_ifid_hold, e_ifid_bubble, e_idex_hold} = '0;
    {e_idex_bubble, e_exmem_hold, e_memwb_bubble} = '0;
    if (rst) begin
      e_ifid_bubble = 1; e_idex_bubble = 1;
    end else if (m_halted) begin
      e_pc_hold = 1; e_ifid_hold = 1; e_idex_hold = 1; e_exmem_hold = 1;
      e_ifid_bubble = 1; e_memwb_bubble = 1;
    end else if (stall_m) begin
      e_pc_hold = 1; e_ifid_hold = 1; e_idex_hold = 1; e_exmem_hold = 1;
      e_memwb_bubble = 1;
    end else if (ex_redirect) begin
      e_ifid_bubble = 1; e_idex_bubble = 1;
    end else if (m_flush_left > 0) begin
      e_ifid_bubble = 1; e_pc_hold = stall_f;
    end else if (model_load_use()) begin
      e_pc_hold = 1; e_ifid_hold = 1; e_idex_bubble = 1;
    end else if (stall_f) begin
      e_pc_hold = 1; e_ifid_bubble = 1;
    end
  endtask

  task automatic model_reset();
    prods = {};
    for (int i = 0; i < SB_DEPTH; i++) prods.push_back('{0, 0, 0});
    m_halted = 0; m_err = 0; m_flush_left = 0; m_wd = 0; m_stall_cnt = 0;
    m_fwd_a = 0; m_fwd_b = 0; m_known = 1;
  endtask

  task automatic model_advance();
    int fa, fb;
    bit frozen;
    if (rst) begin
      model_reset();
      return;
    end
    frozen = m_halted || stall_m;
    if (e_pc_hold && m_stall_cnt < 65535) m_stall_cnt++;
    if (!m_halted && stall_m) begin
      if (m_wd < 65535) m_wd++;
      if (TIMEOUT != 0 && m_wd >= TIMEOUT) m_err = 1;
    end else begin
      m_wd = 0;
    end
    if (!frozen) begin
      fa = youngest(int'(id_rs), id_rs_use);
      fb = youngest(int'(id_rt), id_rt_use);
      m_fwd_a = e_idex_bubble ? 0 : fa;
      m_fwd_b = e_idex_bubble ? 0 : fb;
      prods.push_front('{id_valid && id_wr_en && !e_idex_bubble, int'(id_wr_sel), id_is_load});
      void'(prods.pop_back());
    end
    if (!m_halted) begin
      if (stall_m) m_flush_left = 0;
      else if (ex_redirect) m_flush_left = FLUSH_SLOTS - 1;
      else begin
        if (m_flush_left > 0) m_flush_left--;
        if (halt_m && !e_pc_hold) m_halted = 1;
      end
    end
  endtask

  // One clock cycle: inputs are already applied; sample at the falling edge.
  task automatic tick();
    @(negedge clk);
    model_outputs();
    s_pc_hold = pc_hold; s_ifid_hold = ifid_hold; s_ifid_bubble = ifid_bubble;
    s_idex_bubble = idex_bubble; s_idex_hold = idex_hold;
    s_memwb_bubble = memwb_bubble; s_err = err; s_fwd_a = fwd_a_sel;
    s_stall_cnt = stall_cnt;
    check("pc_hold", pc_hold, e_pc_hold);
    check("ifid_hold", ifid_hold, e_ifid_hold);
    check("ifid_bubble", ifid_bubble, e_ifid_bubble);
    check("idex_hold", idex_hold, e_idex_hold);
    check("idex_bubble", idex_bubble, e_idex_bubble);
    check("exmem_hold", exmem_hold, e_exmem_hold);
    check("memwb_bubble", memwb_bubble, e_memwb_bubble);
    if (m_known) begin
      check("fwd_a_sel", fwd_a_sel, m_fwd_a);
      check("fwd_b_sel", fwd_b_sel, m_fwd_b);
      check("stall_cnt", stall_cnt, m_stall_cnt);
      check("err", err, m_err);
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    id_valid = 0; id_rs = '0; id_rt = '0; id_rs_use = 0; id_rt_use = 0;
    id_wr_en = 0; id_wr_sel = '0; id_is_load = 0;
    ex_redirect = 0; stall_f = 0; stall_m = 0; halt_m = 0;
  endtask

  task automatic instr(input int rs, input bit rs_u, input int rt, input bit rt_u,
                       input bit wr, input int wsel, input bit ld);
    id_valid = 1; id_rs = REG_W'(rs); id_rs_use = rs_u; id_rt = REG_W'(rt);
    id_rt_use = rt_u; id_wr_en = wr; id_wr_sel = REG_W'(wsel); id_is_load = ld;
  endtask

  task automatic do_reset();
    nop(); rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    m_known = 0;
    prods = {};
    for (int i = 0; i < SB_DEPTH; i++) prods.push_back('{0, 0, 0});
    nop();
    rst = 1;

    // Reset behaviour and release.
    tick();
    check("rst_ifid_bubble", s_ifid_bubble, 1);
    check("rst_idex_bubble", s_idex_bubble, 1);
    check("rst_pc_hold", s_pc_hold, 0);
    tick();
    rst = 0;
    tick();
    check("rel_stall_cnt", s_stall_cnt, 0);
    check("rel_fwd_a", s_fwd_a, 0);
    check("rel_ifid_bubble", s_ifid_bubble, 0);
    check("rel_err", s_err, 0);

    // ADD r1; SUB r2,r1; third reads r1.
    instr(2, 1, 3, 1, 1, 1, 0); tick();
    instr(1, 1, 5, 1, 1, 2, 0); tick();
    check("fwd_no_hold", s_pc_hold, 0);
    instr(1, 1, 6, 0, 1, 4, 0); tick();
    check("fwd_a_ex_mem", s_fwd_a, 1);
    nop(); tick();
    check("fwd_a_mem_wb", s_fwd_a, 2);
    tick(); tick(); tick();

    // LD r3; ADD r4,r3 -> one-cycle interlock then forward from MEM/WB.
    instr(6, 1, 0, 0, 1, 3, 1); tick();
    instr(3, 1, 7, 1, 1, 4, 0); tick();
    check("ldu_pc_hold", s_pc_hold, 1);
    check("ldu_ifid_hold", s_ifid_hold, 1);
    check("ldu_idex_bubble", s_idex_bubble, 1);
    tick();
    check("ldu_release", s_pc_hold, 0);
    check("ldu_bubble_fwd", s_fwd_a, 0);
    nop(); tick();
    check("ldu_fwd_a", s_fwd_a, 2);
    tick(); tick(); tick();

    // Single-cycle redirect.
    ex_redirect = 1; tick();
    check("rd_idex_bubble0", s_idex_bubble, 1);
    check("rd_ifid_bubble0", s_ifid_bubble, 1);
    check("rd_pc_hold0", s_pc_hold, 0);
    ex_redirect = 0; tick();
    check("rd_idex_bubble1", s_idex_bubble, 0);
    check("rd_ifid_bubble1", s_ifid_bubble, 1);
    tick();
    check("rd_ifid_bubble2", s_ifid_bubble, 0);

    // Memory wait with a pending redirect.
    do_reset();
    stall_m = 1; ex_redirect = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mw_exmem_hold", s_pc_hold & s_idex_hold & s_memwb_bubble, 1);
    end
    stall_m = 0; tick();
    check("mw_flush_idex", s_idex_bubble, 1);
    check("mw_flush_pc", s_pc_hold, 0);
    ex_redirect = 0; tick();
    check("mw_stall_cnt", s_stall_cnt, 5);
    check("mw_flush_slot2", s_ifid_bubble, 1);

    // Watchdog expiry, halt and error clear.
    do_reset();
    stall_m = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wd_not_yet", s_err, 0);
    end
    tick();
    check("wd_err_set", s_err, 1);
    tick(); tick();
    check("wd_err_sticky", s_err, 1);
    stall_m = 0; halt_m = 1; tick();
    halt_m = 0; tick();
    check("halt_pc_hold", s_pc_hold, 1);
    check("halt_memwb", s_memwb_bubble, 1);
    tick();
    check("halt_absorb", s_pc_hold, 1);
    do_reset();
    tick();
    check("rst_clears_err", s_err, 0);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs       = REG_W'($urandom_range(0, 7));
      id_rt       = REG_W'($urandom_range(0, 7));
      id_rs_use   = id_valid && ($urandom_range(0, 1) == 1);
      id_rt_use   = id_valid && ($urandom_range(0, 1) == 1);
      id_wr_en    = id_valid && ($urandom_range(0, 3) != 0);
      id_wr_sel   = REG_W'($urandom_range(0, 7));
      id_is_load  = id_wr_en && ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      stall_f     = ($urandom_range(0, 7) == 0);
      stall_m     = ($urandom_range(0, 6) == 0);
      halt_m      = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0;
    nop();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
